clkdiv_ratio_ctrl: RTL



---
 rtl/clkdiv_pkg.sv | 25 ++
 rtl/clkdiv_ratio_decode.sv | 30 +++
 rtl/clkdiv_ratio_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the UART clock-divider ratio controller: FSM encoding,
// prescale/ratio constants and default widths.
package clkdiv_pkg;

    localparam int PRESCALE_W_DEF = 6;
    localparam int RATIO_W_DEF    = 8;

    localparam int PSC_32 = 32;
    localparam int PSC_16 = 16;
    localparam int PSC_8  = 8;

    localparam int RATIO_1 = 1;
    localparam int RATIO_2 = 2;
    localparam int RATIO_4 = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WAIT_IDLE,
        ST_DRAIN,
        ST_GATE,
        ST_APPLY
    } state_t;

endpackage

// File: rtl/clkdiv_ratio_decode.sv
// Prescale to divide-ratio decoder (32->1, 16->2, 8->4, else invalid).
// Latency: combinational. Backpressure: none.
// Flow: pure function of the request value, no handshake.
module clkdiv_ratio_decode
    import clkdiv_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF,
    parameter int RATIO_W    = RATIO_W_DEF
) (
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic [RATIO_W-1:0]    o_ratio,
    output logic                  o_valid
);

    always_comb begin
        o_ratio = '0;
        o_valid = 1'b0;
        if (i_prescale == PRESCALE_W'(PSC_32)) begin
            o_ratio = RATIO_W'(RATIO_1);
            o_valid = 1'b1;
        end else if (i_prescale == PRESCALE_W'(PSC_16)) begin
            o_ratio = RATIO_W'(RATIO_2);
            o_valid = 1'b1;
        end else if (i_prescale == PRESCALE_W'(PSC_8)) begin
            o_ratio = RATIO_W'(RATIO_4);
            o_valid = 1'b1;
        end
    end

endmodule

// File: rtl/clkdiv_ratio_ctrl.sv
// Sequences a glitch-safe divide-ratio change: wait UART idle, drain the current
// divided period, gate, load, re-enable. Ack 2 cycles after strobe for invalid/same ratio.
// No backpressure; strobes outside IDLE are dropped unless CLKDIV_CTRL_PENDING_EN is defined.
module clkdiv_ratio_ctrl
    import clkdiv_pkg::*;
#(
    parameter int PRESCALE_W  = PRESCALE_W_DEF,
    parameter int RATIO_W     = RATIO_W_DEF,
    parameter int GATE_CYC    = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Prescale_Valid,
    input  logic                  Tx_Busy,
    input  logic                  Rx_Busy,
    input  logic                  Div_Edge_Tick,
    output logic [RATIO_W-1:0]    Div_Ratio,
    output logic                  Div_En,
    output logic                  Cfg_Ack,
    output logic                  Cfg_Err,
    output logic                  Cfg_Timeout,
    output logic                  Ratio_Update
);

    localparam int CNT_MAX = (TIMEOUT_CYC > GATE_CYC) ? TIMEOUT_CYC : GATE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                r_state, w_state_nxt;
    logic [PRESCALE_W-1:0] r_req, w_req_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_to_flag, w_to_flag_nxt;
    logic [RATIO_W-1:0]    r_div_ratio, w_div_ratio_nxt;
    logic                  r_div_en, w_div_en_nxt;
    logic                  r_ack, w_ack_nxt;
    logic                  r_err, w_err_nxt;
    logic                  r_timeout, w_timeout_nxt;
    logic                  r_upd, w_upd_nxt;
    logic [RATIO_W-1:0]    w_dec_ratio;
    logic                  w_dec_vld;
`ifdef CLKDIV_CTRL_PENDING_EN
    logic                  r_pend_vld, w_pend_vld_nxt;
    logic [PRESCALE_W-1:0] r_pend_dat, w_pend_dat_nxt;
`endif

    // r_req only changes in IDLE, so the decode stays valid through APPLY.
    clkdiv_ratio_decode #(
        .PRESCALE_W (PRESCALE_W),
        .RATIO_W    (RATIO_W)
    ) u_decode (
        .i_prescale (r_req),
        .o_ratio    (w_dec_ratio),
        .o_valid    (w_dec_vld)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_cnt_nxt       = r_cnt;
        w_to_flag_nxt   = r_to_flag;
        w_div_ratio_nxt = r_div_ratio;
        w_div_en_nxt    = r_div_en;
        w_ack_nxt       = 1'b0;
        w_err_nxt       = 1'b0;
        w_timeout_nxt   = 1'b0;
        w_upd_nxt       = 1'b0;
`ifdef CLKDIV_CTRL_PENDING_EN
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_dat_nxt  = r_pend_dat;
`endif
        case (r_state)
            ST_IDLE: begin
                if (Prescale_Valid) begin
                    w_req_nxt   = Prescale;
                    w_state_nxt = ST_CHECK;
`ifdef CLKDIV_CTRL_PENDING_EN
                    w_pend_vld_nxt = 1'b0;
                end else if (r_pend_vld) begin
                    w_req_nxt      = r_pend_dat;
                    w_state_nxt    = ST_CHECK;
                    w_pend_vld_nxt = 1'b0;
`endif
                end
            end
            ST_CHECK: begin
                if (!w_dec_vld) begin
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_dec_ratio == r_div_ratio) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (!(Tx_Busy || Rx_Busy)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A tick on the timeout cycle still counts as a clean drain.
                if (Div_Edge_Tick) begin
                    w_cnt_nxt    = '0;
                    w_div_en_nxt = 1'b0;
                    w_state_nxt  = ST_GATE;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_cnt_nxt     = '0;
                    w_div_en_nxt  = 1'b0;
                    w_to_flag_nxt = 1'b1;
                    w_state_nxt   = ST_GATE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_GATE: begin
                if (r_cnt == CNT_W'(GATE_CYC - 1)) begin
                    w_div_ratio_nxt = w_dec_ratio;
                    w_upd_nxt       = 1'b1;
                    w_state_nxt     = ST_APPLY;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_APPLY: begin
                w_div_en_nxt  = 1'b1;
                w_ack_nxt     = 1'b1;
                w_timeout_nxt = r_to_flag;
                w_to_flag_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
`ifdef CLKDIV_CTRL_PENDING_EN
        if ((r_state != ST_IDLE) && Prescale_Valid) begin
            w_pend_vld_nxt = 1'b1;
            w_pend_dat_nxt = Prescale;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_cnt       <= '0;
            r_to_flag   <= 1'b0;
            r_div_ratio <= RATIO_W'(RATIO_1);
            r_div_en    <= 1'b1;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
            r_upd       <= 1'b0;
`ifdef CLKDIV_CTRL_PENDING_EN
            r_pend_vld  <= 1'b0;
            r_pend_dat  <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_cnt       <= w_cnt_nxt;
            r_to_flag   <= w_to_flag_nxt;
            r_div_ratio <= w_div_ratio_nxt;
            r_div_en    <= w_div_en_nxt;
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_timeout   <= w_timeout_nxt;
            r_upd       <= w_upd_nxt;
`ifdef CLKDIV_CTRL_PENDING_EN
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_dat  <= w_pend_dat_nxt;
`endif
        end
    end

    assign Div_Ratio    = r_div_ratio;
    assign Div_En       = r_div_en;
    assign Cfg_Ack      = r_ack;
    assign Cfg_Err      = r_err;
    assign Cfg_Timeout  = r_timeout;
    assign Ratio_Update = r_upd;

endmodule
